// File: rtl/note_pkg.sv
// Shared definitions for the note sequencer: note codes, FSM states and ROM entry layout.
package note_pkg;

  typedef enum logic [3:0] {
    NOTE_C    = 4'd0,
    NOTE_D    = 4'd1,
    NOTE_E    = 4'd2,
    NOTE_F    = 4'd3,
    NOTE_G    = 4'd4,
    NOTE_A    = 4'd5,
    NOTE_B    = 4'd6,
    NOTE_C2   = 4'd7,
    NOTE_REST = 4'd8
  } note_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PLAY,
    ST_PAUSE
  } state_e;

  // ROM entries are packed {note, duration}, duration in the low bits.
  localparam int ENTRY_DUR_LSB = 0;

  function automatic int entry_note_lsb(int dur_w);
    return ENTRY_DUR_LSB + dur_w;
  endfunction

endpackage

// File: rtl/song_rom.sv
// Song table with one-cycle synchronous read; address is {song, entry}.
// Any entry not listed reads back as duration 0, the end-of-song marker.
module song_rom
  import note_pkg::*;
#(
  parameter int NOTE_W = 4,
  parameter int DUR_W  = 4,
  parameter int ADDR_W = 6,
  parameter int SEL_W  = 1
) (
  input  logic                      clk,
  input  logic [SEL_W+ADDR_W-1:0]   addr,
  output logic [NOTE_W+DUR_W-1:0]   entry
);

  localparam int ENTRY_W  = NOTE_W + DUR_W;
  localparam int NOTE_LSB = entry_note_lsb(DUR_W);

  function automatic logic [ENTRY_W-1:0] mk(note_e n, int d);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[NOTE_LSB +: NOTE_W]      = NOTE_W'(n);
    e[ENTRY_DUR_LSB +: DUR_W]  = DUR_W'(d);
    return e;
  endfunction

  logic [ENTRY_W-1:0] lookup;

  always_comb begin
    lookup = mk(NOTE_REST, 0);
    case (int'(addr[SEL_W+ADDR_W-1:ADDR_W]))
      0: begin
        case (int'(addr[ADDR_W-1:0]))
          0:       lookup = mk(NOTE_E, 2);
          1:       lookup = mk(NOTE_REST, 1);
          2:       lookup = mk(NOTE_G, 1);
          default: ;
        endcase
      end
      // Song 1 opens with the end marker, so it never sounds.
      1: begin
        case (int'(addr[ADDR_W-1:0]))
          1:       lookup = mk(NOTE_C, 1);
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    entry <= lookup;
  end

endmodule

// File: rtl/note_sequencer.sv
// Plays run-length-encoded songs from song_rom with play/pause, stop and looping.
// Define NOTE_SEQ_ARTIC_GAP_EN to rest for the last GAP_TICKS cycles of every note.
module note_sequencer
  import note_pkg::*;
#(
  parameter int BEAT_TICKS = 1000000,
  parameter int NOTE_W     = 4,
  parameter int DUR_W      = 4,
  parameter int ADDR_W     = 6,
  parameter int NUM_SONGS  = 2,
  parameter int SEL_W      = 1,
  parameter int GAP_TICKS  = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              toggle,
  input  logic              stop,
  input  logic [SEL_W-1:0]  song_sel,
  input  logic              loop_en,
  output logic [NOTE_W-1:0] ns,
  output logic              enable,
  output logic              beat,
  output logic              done
);

  localparam int                ENTRY_W   = NOTE_W + DUR_W;
  localparam int                NOTE_LSB  = entry_note_lsb(DUR_W);
  localparam logic [NOTE_W-1:0] REST_CODE = NOTE_W'(NOTE_REST);
  localparam logic [31:0]       LAST_TICK = 32'(BEAT_TICKS - 1);

  state_e              state, state_nx;
  logic [SEL_W-1:0]    song_q, song_nx, sel_clamped;
  logic [ADDR_W-1:0]   addr_q, addr_nx;
  logic [NOTE_W-1:0]   note_q, note_nx, first_note_q, first_note_nx;
  logic [DUR_W-1:0]    dur_cnt, dur_nx, note_dur_q, note_dur_nx, first_dur_q, first_dur_nx;
  logic [31:0]         beat_cnt, beat_nx;
  logic                toggle_q, done_q, done_nx;
  logic                toggle_edge, last_tick, song_end, in_gap;

  logic [SEL_W+ADDR_W-1:0] rom_addr;
  logic [ENTRY_W-1:0]      rom_entry;
  logic [NOTE_W-1:0]       rom_note;
  logic [DUR_W-1:0]        rom_dur;

  song_rom #(
    .NOTE_W (NOTE_W),
    .DUR_W  (DUR_W),
    .ADDR_W (ADDR_W),
    .SEL_W  (SEL_W)
  ) u_rom (
    .clk   (clk),
    .addr  (rom_addr),
    .entry (rom_entry)
  );

  assign rom_note    = rom_entry[NOTE_LSB +: NOTE_W];
  assign rom_dur     = rom_entry[ENTRY_DUR_LSB +: DUR_W];
  assign toggle_edge = toggle & ~toggle_q;
  assign last_tick   = (beat_cnt == LAST_TICK);
  assign song_end    = (addr_q == {ADDR_W{1'b1}}) || (rom_dur == '0);

  always_comb begin
    sel_clamped = song_sel;
    if (int'(song_sel) >= NUM_SONGS) sel_clamped = SEL_W'(NUM_SONGS - 1);
  end

  // Outside IDLE the ROM always looks one entry ahead, so the next note is ready
  // when the current one ends; the address wraps to entry 0 after the last slot.
  always_comb begin
    if (state == ST_IDLE) rom_addr = {sel_clamped, {ADDR_W{1'b0}}};
    else                  rom_addr = {song_q, addr_q + ADDR_W'(1)};
  end

  always_comb begin
    state_nx      = state;
    song_nx       = song_q;
    addr_nx       = addr_q;
    note_nx       = note_q;
    dur_nx        = dur_cnt;
    note_dur_nx   = note_dur_q;
    beat_nx       = beat_cnt;
    first_note_nx = first_note_q;
    first_dur_nx  = first_dur_q;
    done_nx       = 1'b0;
    if (stop) begin
      state_nx = ST_IDLE;
      addr_nx  = '0;
      dur_nx   = '0;
      beat_nx  = '0;
      note_nx  = REST_CODE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (toggle_edge) begin
            song_nx  = sel_clamped;
            addr_nx  = '0;
            state_nx = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (rom_dur == '0) begin
            done_nx  = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            note_nx       = rom_note;
            dur_nx        = rom_dur;
            note_dur_nx   = rom_dur;
            first_note_nx = rom_note;
            first_dur_nx  = rom_dur;
            beat_nx       = '0;
            state_nx      = ST_PLAY;
          end
        end
        // The cycle in which a pause is requested still counts as played time.
        ST_PLAY: begin
          if (!last_tick) begin
            beat_nx = beat_cnt + 32'd1;
          end else begin
            beat_nx = '0;
            if (dur_cnt != DUR_W'(1)) begin
              dur_nx = dur_cnt - DUR_W'(1);
            end else if (!song_end) begin
              note_nx     = rom_note;
              dur_nx      = rom_dur;
              note_dur_nx = rom_dur;
              addr_nx     = addr_q + ADDR_W'(1);
            end else if (loop_en) begin
              note_nx     = first_note_q;
              dur_nx      = first_dur_q;
              note_dur_nx = first_dur_q;
              addr_nx     = '0;
            end else begin
              state_nx = ST_IDLE;
              done_nx  = 1'b1;
              addr_nx  = '0;
              dur_nx   = '0;
              note_nx  = REST_CODE;
            end
          end
          if (toggle_edge && state_nx == ST_PLAY) state_nx = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (toggle_edge) state_nx = ST_PLAY;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      song_q       <= '0;
      addr_q       <= '0;
      note_q       <= REST_CODE;
      dur_cnt      <= '0;
      note_dur_q   <= '0;
      beat_cnt     <= '0;
      first_note_q <= '0;
      first_dur_q  <= '0;
      toggle_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_nx;
      song_q       <= song_nx;
      addr_q       <= addr_nx;
      note_q       <= note_nx;
      dur_cnt      <= dur_nx;
      note_dur_q   <= note_dur_nx;
      beat_cnt     <= beat_nx;
      first_note_q <= first_note_nx;
      first_dur_q  <= first_dur_nx;
      toggle_q     <= toggle;
      done_q       <= done_nx;
    end
  end

`ifdef NOTE_SEQ_ARTIC_GAP_EN
  logic [63:0] note_len, remaining;

  // A gap as long as the whole note would silence it, so fall back to the last beat.
  always_comb begin
    note_len  = 64'(note_dur_q) * 64'(BEAT_TICKS);
    remaining = (64'(dur_cnt) - 64'd1) * 64'(BEAT_TICKS) + 64'(BEAT_TICKS) - 64'(beat_cnt);
    if (64'(GAP_TICKS) < note_len) in_gap = (remaining <= 64'(GAP_TICKS));
    else                           in_gap = (dur_cnt == DUR_W'(1));
  end
`else
  logic unused_gap_cfg;
  assign in_gap         = 1'b0;
  assign unused_gap_cfg = ^{note_dur_q, (GAP_TICKS > 0)};
`endif

  assign enable = (state == ST_PLAY);
  assign beat   = enable && last_tick;
  assign done   = done_q;
  assign ns     = (enable && !in_gap) ? note_q : REST_CODE;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: constant vector table, directed corner sequences
// and random stimulus against a remaining-cycles reference model.
module tb_note_sequencer;

  localparam int BT = 4;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_PLAY  = 2;
  localparam int M_PAUSE = 3;

  logic       clk, rst_n, toggle, stop, loop_en;
  logic [1:0] song_sel;
  logic [3:0] ns;
  logic       enable, beat, done;

  int checks = 0;
  int errors = 0;

  note_sequencer #(
    .BEAT_TICKS (BT),
    .NOTE_W     (4),
    .DUR_W      (4),
    .ADDR_W     (2),
    .NUM_SONGS  (2),
    .SEL_W      (2),
    .GAP_TICKS  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .toggle   (toggle),
    .stop     (stop),
    .song_sel (song_sel),
    .loop_en  (loop_en),
    .ns       (ns),
    .enable   (enable),
    .beat     (beat),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song contents as written down for the sequencer (note codes, beats).
  int ref_note [0:1][0:3] = '{'{2, 8, 4, 0}, '{0, 0, 0, 0}};
  int ref_dur  [0:1][0:3] = '{'{2, 1, 1, 0}, '{0, 1, 0, 0}};

  int m_mode, m_song, m_idx, m_rem;
  bit m_done, m_ptog;

  function automatic int rdur(int s, int i);
    if (i > 3) return 0;
    return ref_dur[s][i];
  endfunction

  task automatic modelReset();
    m_mode = M_IDLE; m_song = 0; m_idx = 0; m_rem = 0; m_done = 0; m_ptog = 0;
  endtask

  // Model keeps the number of cycles left in the current note.
  task automatic modelStep(input bit t, input bit s, input bit l, input int sel);
    bit edge_seen;
    int ni;
    edge_seen = t && !m_ptog;
    m_ptog = t;
    m_done = 0;
    if (s) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (edge_seen) begin
          m_song = (sel >= 2) ? 1 : sel;
          m_mode = M_FETCH;
        end
        M_FETCH: begin
          if (rdur(m_song, 0) == 0) begin
            m_done = 1; m_mode = M_IDLE;
          end else begin
            m_idx = 0; m_rem = rdur(m_song, 0) * BT; m_mode = M_PLAY;
          end
        end
        M_PLAY: begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            ni = m_idx + 1;
            if (m_idx == 3 || rdur(m_song, ni) == 0) begin
              if (l) begin
                m_idx = 0; m_rem = rdur(m_song, 0) * BT;
              end else begin
                m_mode = M_IDLE; m_done = 1;
              end
            end else begin
              m_idx = ni; m_rem = rdur(m_song, ni) * BT;
            end
          end
          if (edge_seen && m_mode == M_PLAY) m_mode = M_PAUSE;
        end
        default: if (edge_seen) m_mode = M_PLAY;
      endcase
    end
  endtask

  task automatic applyStimulus(input bit t, input bit s, input bit l, input logic [1:0] sel);
    toggle = t; stop = s; loop_en = l; song_sel = sel;
    @(posedge clk);
    modelStep(t, s, l, int'(sel));
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] ens, input bit een,
                             input bit ebt, input bit edn);
    checks++;
    if (ns !== ens || enable !== een || beat !== ebt || done !== edn) begin
      errors++;
      $display("[TB] FAIL %s: got ns=%0d enable=%0d beat=%0d done=%0d, expected ns=%0d enable=%0d beat=%0d done=%0d",
               name, ns, enable, beat, done, ens, een, ebt, edn);
    end
  endtask

  task automatic checkModel(input string name);
    bit en;
    logic [3:0] ens;
    en  = (m_mode == M_PLAY);
    ens = en ? 4'(ref_note[m_song][m_idx]) : 4'd8;
    checkOutput(name, ens, en, en && (m_rem % BT == 1), m_done);
  endtask

  typedef struct {
    bit         tog;
    bit         stp;
    bit         lp;
    logic [1:0] sel;
    logic [3:0] ens;
    bit         een;
    bit         ebt;
    bit         edn;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit t, logic [3:0] e_ns, bit e_en, bit e_bt, bit e_dn);
    vec_t v;
    v.tog = t; v.stp = 0; v.lp = 0; v.sel = 2'd0;
    v.ens = e_ns; v.een = e_en; v.ebt = e_bt; v.edn = e_dn;
    tbl.push_back(v);
  endfunction

  initial begin
    // Song 0 once through: FETCH, E for 8, REST for 4, G for 4, done, idle.
    add(1, 8, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      add(0, 2, 1, 0, 0); add(0, 2, 1, 0, 0); add(0, 2, 1, 0, 0); add(0, 2, 1, 1, 0);
    end
    add(0, 8, 1, 0, 0); add(0, 8, 1, 0, 0); add(0, 8, 1, 0, 0); add(0, 8, 1, 1, 0);
    add(0, 4, 1, 0, 0); add(0, 4, 1, 0, 0); add(0, 4, 1, 0, 0); add(0, 4, 1, 1, 0);
    add(0, 8, 0, 0, 1);
    add(0, 8, 0, 0, 0);

    rst_n = 1'b0; toggle = 0; stop = 0; loop_en = 0; song_sel = 2'd0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("reset_state", 8, 0, 0, 0);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].tog, tbl[i].stp, tbl[i].lp, tbl[i].sel);
      checkOutput($sformatf("table_%0d", i), tbl[i].ens, tbl[i].een, tbl[i].ebt, tbl[i].edn);
    end

    // Looping: E must follow G directly with no done pulse.
    applyStimulus(1, 0, 1, 0);
    checkModel("loop_fetch");
    for (int i = 1; i < 40; i++) begin
      applyStimulus(0, 0, 1, 0);
      if (i == 17) checkOutput("loop_restart", 2, 1, 0, 0);
      else         checkModel($sformatf("loop_%0d", i));
    end
    applyStimulus(0, 1, 1, 0);
    checkOutput("loop_stop", 8, 0, 0, 0);

    // Pause three cycles into E, hold, resume for the remaining five cycles.
    applyStimulus(1, 0, 0, 0);
    checkOutput("pause_fetch", 8, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("pause_pre", 2, 1, 0, 0);
    end
    applyStimulus(1, 0, 0, 0);
    checkOutput("pause_enter", 8, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("pause_hold", 8, 0, 0, 0);
    end
    applyStimulus(1, 0, 0, 0);
    checkOutput("resume_first", 2, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("resume_mid", 2, 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("resume_last", 2, 1, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("resume_next", 8, 1, 0, 0);

    // Stop together with a toggle edge: idle, edge consumed, next toggle restarts.
    applyStimulus(1, 1, 0, 0);
    checkOutput("stop_toggle", 8, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("stop_idle", 8, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("restart_fetch", 8, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("restart_e", 2, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("restart_stop", 8, 0, 0, 0);

    // Empty song, selected directly and through clamping.
    applyStimulus(1, 0, 0, 1);
    checkOutput("s1_fetch", 8, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("s1_done", 8, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("s1_idle", 8, 0, 0, 0);
    applyStimulus(1, 0, 0, 3);
    checkOutput("s3_fetch", 8, 0, 0, 0);
    applyStimulus(0, 0, 0, 3);
    checkOutput("s3_done", 8, 0, 0, 1);
    applyStimulus(0, 0, 0, 3);
    checkOutput("s3_idle", 8, 0, 0, 0);

    // Asynchronous reset in the middle of a note.
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("pre_reset_e", 2, 1, 0, 0);
    rst_n = 1'b0;
    #2;
    checkOutput("async_reset", 8, 0, 0, 0);
    modelReset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0,
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      checkModel($sformatf("random_%0d", i));
    end

    $display("[TB] directed and random phases complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
